spike_event_encoder: RTL and testbench

- Downstream consumer of the Izhikevich neuron core. Samples the neuron's 8-bit signed membrane-voltage output (`uo_out`, integer part of `v1`) every enabled cycle.
- Detects spikes with hysteresis and emits a one-cycle spike pulse.
- Measures inter-spike intervals (ISI) and buffers them in a small FIFO for host readout.
- Reports a windowed spike-rate count. Turns the raw voltage trace into compact event data for pin-limited output.

---
 rtl/izh_pkg.sv | 21 ++
 rtl/spike_event_encoder_if.sv | 37 +++
 rtl/izh_sync_fifo.sv | 79 +++++++
 rtl/spike_event_encoder.sv | 117 +++++++++++
 tb/tb_spike_event_encoder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/izh_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : izh_pkg
//  Description : Shared types and constants for the Izhikevich neuron blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package izh_pkg;

    localparam int c_volt_w = 8;

    // Integer voltage scale of the neuron core: fires at 30, rests well below 0
    localparam logic signed [c_volt_w-1:0] c_def_thresh = 8'sd30;
    localparam logic signed [c_volt_w-1:0] c_def_rearm  = 8'sd0;

    typedef enum logic [0:0] {
        ARMED   = 1'b0,
        REFRACT = 1'b1
    } det_state_e;

endpackage
`default_nettype wire

// File: rtl/spike_event_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : spike_event_encoder_if
//  Description : Voltage-sample input and event-data output bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spike_event_encoder_if #(
    parameter int ISI_W  = 16,
    parameter int RATE_W = 8
);
    import izh_pkg::*;

    logic                        ena;
    logic signed [c_volt_w-1:0]  v_in;
    logic signed [c_volt_w-1:0]  thresh;
    logic signed [c_volt_w-1:0]  rearm;
    logic                        rd_en;
    logic                        spike;
    logic [ISI_W-1:0]            isi_data;
    logic                        isi_valid;
    logic                        fifo_full;
    logic                        overflow;
    logic [RATE_W-1:0]           rate;
    logic                        rate_valid;

    modport master (
        output ena, v_in, thresh, rearm, rd_en,
        input  spike, isi_data, isi_valid, fifo_full, overflow, rate, rate_valid
    );

    modport slave (
        input  ena, v_in, thresh, rearm, rd_en,
        output spike, isi_data, isi_valid, fifo_full, overflow, rate, rate_valid
    );

endinterface
`default_nettype wire

// File: rtl/izh_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : izh_sync_fifo
//  Description : Show-ahead synchronous FIFO; DEPTH must be a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module izh_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_full,
    output logic                  o_drop
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w+1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic [c_ptr_w:0]   w_count_d;
    logic               r_valid;
    logic               r_full;
    logic               w_do_pop;
    logic               w_do_push;

    // A pop frees the slot this cycle, so a full FIFO still accepts a push
    always_comb begin
        w_do_pop  = i_pop && r_valid;
        w_do_push = i_push && (!r_full || w_do_pop);
        o_drop    = i_push && r_full && !w_do_pop;
        w_count_d = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_d = r_count + 1'b1;
        end else if (!w_do_push && w_do_pop) begin
            w_count_d = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_d;
            r_valid <= (w_count_d != '0);
            r_full  <= (w_count_d == c_depth);
        end
    end

    assign o_data  = r_valid ? r_mem[r_rd_ptr] : '0;
    assign o_valid = r_valid;
    assign o_full  = r_full;

endmodule
`default_nettype wire

// File: rtl/spike_event_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : spike_event_encoder
//  Description : Hysteretic spike detector with ISI FIFO and windowed rate.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_event_encoder
    import izh_pkg::*;
#(
    parameter int ISI_W      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int WINDOW_LEN = 1024,
    parameter int RATE_W     = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    spike_event_encoder_if.slave   bus
);

    localparam int                 c_win_w    = $clog2(WINDOW_LEN);
    localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW_LEN - 1);
    localparam logic [ISI_W-1:0]   c_isi_max  = '1;
    localparam logic [RATE_W-1:0]  c_rate_max = '1;

    det_state_e          r_state;
    logic [ISI_W-1:0]    r_isi_cnt;
    logic                r_have_ref;
    logic                r_spike;
    logic                r_overflow;
    logic                r_rate_valid;
    logic [c_win_w-1:0]  r_win_cnt;
    logic [RATE_W-1:0]   r_spk_cnt;
    logic [RATE_W-1:0]   r_rate;

    logic                w_spike_now;
    logic                w_rearm_now;
    logic                w_win_end;
    logic                w_push;
    logic                w_drop;
    logic [ISI_W-1:0]    w_isi_val;
    logic [RATE_W-1:0]   w_spk_next;

    // Voltage ports are signed, so these are signed comparisons
    always_comb begin
        w_spike_now = bus.ena && (r_state == ARMED)   && (bus.v_in > bus.thresh);
        w_rearm_now = bus.ena && (r_state == REFRACT) && (bus.v_in < bus.rearm);
        w_isi_val   = (r_isi_cnt == c_isi_max) ? c_isi_max : r_isi_cnt + 1'b1;
        w_push      = w_spike_now && r_have_ref;
        w_win_end   = bus.ena && (r_win_cnt == c_win_last);
        w_spk_next  = (w_spike_now && (r_spk_cnt != c_rate_max)) ? r_spk_cnt + 1'b1
                                                                 : r_spk_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARMED;
            r_isi_cnt    <= '0;
            r_have_ref   <= 1'b0;
            r_spike      <= 1'b0;
            r_overflow   <= 1'b0;
            r_rate_valid <= 1'b0;
            r_win_cnt    <= '0;
            r_spk_cnt    <= '0;
            r_rate       <= '0;
        end else begin
            r_spike      <= w_spike_now;
            r_rate_valid <= w_win_end;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (bus.ena) begin
                if (w_spike_now) begin
                    r_state <= REFRACT;
                end else if (w_rearm_now) begin
                    r_state <= ARMED;
                end
                if (w_spike_now) begin
                    r_isi_cnt  <= '0;
                    r_have_ref <= 1'b1;
                end else begin
                    r_isi_cnt  <= w_isi_val;
                end
                // A spike on the closing cycle belongs to the closing window
                if (w_win_end) begin
                    r_rate    <= w_spk_next;
                    r_spk_cnt <= '0;
                    r_win_cnt <= '0;
                end else begin
                    r_spk_cnt <= w_spk_next;
                    r_win_cnt <= r_win_cnt + 1'b1;
                end
            end
        end
    end

    izh_sync_fifo #(
        .WIDTH (ISI_W),
        .DEPTH (FIFO_DEPTH)
    ) u_isi_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_isi_val),
        .i_pop   (bus.rd_en),
        .o_data  (bus.isi_data),
        .o_valid (bus.isi_valid),
        .o_full  (bus.fifo_full),
        .o_drop  (w_drop)
    );

    assign bus.spike      = r_spike;
    assign bus.overflow   = r_overflow;
    assign bus.rate       = r_rate;
    assign bus.rate_valid = r_rate_valid;

endmodule
`default_nettype wire

// File: tb/tb_spike_event_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_event_encoder
//  Description : Directed self-checking bench for spike_event_encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spike_event_encoder;
    import izh_pkg::*;

    localparam int ISI_W      = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int WINDOW_LEN = 16;
    localparam int RATE_W     = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    spike_event_encoder_if #(.ISI_W(ISI_W), .RATE_W(RATE_W)) bus ();

    spike_event_encoder #(
        .ISI_W      (ISI_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .WINDOW_LEN (WINDOW_LEN),
        .RATE_W     (RATE_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int v);
        bus.v_in = v[7:0];
        step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves rst asserted across two edges, then releases it without stepping
    task automatic do_reset();
        rst       = 1'b1;
        bus.ena   = 1'b0;
        bus.rd_en = 1'b0;
        bus.v_in  = -8'sd65;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.thresh = c_def_thresh;
        bus.rearm  = c_def_rearm;

        // Reset state and first spike
        do_reset();
        chk("rst_spike", bus.spike, 0);
        chk("rst_isi_valid", bus.isi_valid, 0);
        chk("rst_full", bus.fifo_full, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_rate", bus.rate, 0);
        chk("rst_rate_valid", bus.rate_valid, 0);
        chk("rst_isi_data", bus.isi_data, 0);
        bus.ena = 1'b1;
        sample(40);  chk("first_spike", bus.spike, 1);
        sample(35);  chk("spike_pulse_end", bus.spike, 0);
        chk("first_no_push", bus.isi_valid, 0);
        sample(20);  chk("hyst_20", bus.spike, 0);
        sample(40);  chk("hyst_no_retrigger", bus.spike, 0);
        sample(-65); chk("hyst_rearm", bus.spike, 0);
        sample(40);  chk("second_spike", bus.spike, 1);
        chk("second_push_valid", bus.isi_valid, 1);
        chk("second_isi", bus.isi_data, 5);

        // Equality boundaries and reset flushing the FIFO
        do_reset();
        bus.ena = 1'b1;
        sample(30);  chk("eq_thresh_no_spike", bus.spike, 0);
        sample(40);  chk("eq_spike_a", bus.spike, 1);
        sample(0);
        sample(40);  chk("eq_rearm_no_rearm", bus.spike, 0);
        sample(-1);
        sample(40);  chk("eq_spike_b", bus.spike, 1);
        chk("eq_isi", bus.isi_data, 4);
        do_reset();
        chk("flush_valid", bus.isi_valid, 0);
        chk("flush_data", bus.isi_data, 0);

        // ISI of 15 between enabled cycles 10 and 25
        bus.ena = 1'b1;
        repeat (9) sample(-65);
        sample(40);  chk("isi10_spike", bus.spike, 1);
        chk("isi10_no_push", bus.isi_valid, 0);
        repeat (14) sample(-65);
        sample(40);
        chk("isi15_valid", bus.isi_valid, 1);
        chk("isi15_data", bus.isi_data, 15);
        bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
        chk("isi15_popped", bus.isi_valid, 0);

        // Same ISI with a 5-cycle enable gap carrying an above-threshold voltage
        do_reset();
        bus.ena = 1'b1;
        repeat (9) sample(-65);
        sample(40);
        repeat (7) sample(-65);
        bus.ena = 1'b0;
        bus.v_in = 8'sd40;
        repeat (5) step();
        chk("gap_no_spike", bus.spike, 0);
        chk("gap_no_push", bus.isi_valid, 0);
        bus.ena = 1'b1;
        repeat (7) sample(-65);
        sample(40);
        chk("gap_isi_data", bus.isi_data, 15);
        bus.ena = 1'b0;
        bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
        chk("gap_pop_while_disabled", bus.isi_valid, 0);
        bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
        chk("empty_pop_valid", bus.isi_valid, 0);
        chk("empty_pop_full", bus.fifo_full, 0);

        // Fill, simultaneous push+pop while full, overflow, ordered drain; ISI_j = j+1
        do_reset();
        bus.ena = 1'b1;
        sample(40);
        for (int j = 2; j <= 11; j++) begin
            repeat (j) sample(-65);
            if (j == 10) begin
                chk("pp_head_before", bus.isi_data, 3);
                bus.rd_en = 1'b1;
            end
            sample(40);
            bus.rd_en = 1'b0;
            if (j == 8) chk("full_after_8", bus.fifo_full, 0);
            if (j == 9) begin
                chk("full_after_9", bus.fifo_full, 1);
                chk("ovf_after_9", bus.overflow, 0);
            end
            if (j == 10) begin
                chk("pp_full_kept", bus.fifo_full, 1);
                chk("pp_ovf_kept", bus.overflow, 0);
                chk("pp_head_after", bus.isi_data, 4);
            end
            if (j == 11) begin
                chk("ovf_after_11", bus.overflow, 1);
                chk("full_after_11", bus.fifo_full, 1);
                chk("drop_head", bus.isi_data, 4);
            end
        end
        bus.ena = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            chk($sformatf("drain_%0d", k), bus.isi_data, 32'(4 + k));
            bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
            if (k == 0) chk("full_clear_after_pop", bus.fifo_full, 0);
        end
        chk("drain_empty", bus.isi_valid, 0);
        chk("ovf_sticky", bus.overflow, 1);

        // ISI counter saturation
        do_reset();
        bus.ena = 1'b1;
        sample(40);
        repeat (70000) sample(-65);
        sample(40);
        chk("sat_isi", bus.isi_data, 16'hFFFF);

        // Rate window: spikes on cycles 2, 6 and the boundary cycle 15
        do_reset();
        bus.ena = 1'b1;
        for (int c = 0; c < 2 * WINDOW_LEN; c++) begin
            sample((c == 2 || c == 6 || c == 15) ? 40 : -65);
            if (c == 14) chk("rate_valid_pre", bus.rate_valid, 0);
            if (c == 15) begin
                chk("rate_win1", bus.rate, 3);
                chk("rate_valid_win1", bus.rate_valid, 1);
            end
            if (c == 16) begin
                chk("rate_valid_one_cycle", bus.rate_valid, 0);
                chk("rate_held", bus.rate, 3);
            end
            if (c == 30) chk("rate_valid_pre2", bus.rate_valid, 0);
            if (c == 31) begin
                chk("rate_win2", bus.rate, 0);
                chk("rate_valid_win2", bus.rate_valid, 1);
            end
        end
        bus.ena = 1'b0;
        step();
        chk("rate_valid_disabled", bus.rate_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
